// File: rtl/adder_slice_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract built from one shared 4-bit ripple slice, LS nibble first.
// Optional build macro OVERFLOW_FLAG_EN adds a registered signed-overflow flag on ovf.
module adder_slice_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    generate
        if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
            $error("adder_slice_sequencer: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] result_r;
    logic [CNT_W-1:0] cnt_r;
    logic             carry_r;
    logic             cout_r;
    logic             out_valid_r;
    logic             in_ready_r;
    logic             accept_s;
    logic             last_s;
    logic [3:0]       a_nib_s;
    logic [3:0]       b_nib_s;
    logic [4:0]       slice_s;

    // 4-bit ripple full-adder slice: returns {carry_out, sum}
    function automatic logic [4:0] slice_add(input logic [3:0] x, input logic [3:0] y,
                                             input logic ci);
        logic       c;
        logic [3:0] s;
        c = ci;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
        end
        return {c, s};
    endfunction

    assign accept_s = (state_r == IDLE) && in_valid && in_ready_r;
    assign last_s   = (state_r == COMPUTE) && (cnt_r == LAST_CNT);
    assign a_nib_s  = a_r[{cnt_r, 2'b00} +: 4];
    assign b_nib_s  = b_r[{cnt_r, 2'b00} +: 4];
    assign slice_s  = slice_add(a_nib_s, b_nib_s, carry_r);

    // Next-state logic for the accept / step / hand-off sequence
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = COMPUTE;
                end else begin
                    state_s = IDLE;
                end
            end
            COMPUTE: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = COMPUTE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    // Operand capture and per-nibble slice stepping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            result_r <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            carry_r  <= 1'b0;
            cout_r   <= 1'b0;
        end else if (accept_s) begin
            // Subtract is A + ~B + 1: invert B here and seed the carry with sub
            a_r     <= a;
            b_r     <= b ^ {WIDTH{sub}};
            carry_r <= sub;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (state_r == COMPUTE) begin
            result_r[{cnt_r, 2'b00} +: 4] <= slice_s[3:0];
            carry_r                       <= slice_s[4];
            if (last_s) begin
                cout_r <= slice_s[4];
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end else begin
            carry_r <= carry_r;
        end
    end

`ifdef OVERFLOW_FLAG_EN
    logic ovf_r;
    logic msb_cin_s;

    // On the last step the slice MSB is the word MSB, so its carry-in is recoverable from the sum
    assign msb_cin_s = a_nib_s[3] ^ b_nib_s[3] ^ slice_s[3];

    // Signed overflow flag: cleared on accept, captured on the final slice step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (accept_s) begin
            ovf_r <= 1'b0;
        end else if (last_s) begin
            ovf_r <= msb_cin_s ^ slice_s[4];
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    // in_ready must read low for the whole time reset is held
    assign in_ready  = in_ready_r & rst_n;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign cout      = cout_r;

endmodule

// File: tb/tb_adder_slice_sequencer.sv
// Self-checking bench for adder_slice_sequencer: directed vector table, corner sequences, random ops.
module tb_adder_slice_sequencer;

    localparam int W      = 16;
    localparam int NSLICE = W / 4;
`ifdef OVERFLOW_FLAG_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    int checks;
    int failures;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    vec_t vecs[9];

    adder_slice_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                         output logic [W-1:0] res, output logic co, output logic ov);
        longint ua;
        longint ub;
        longint sa;
        longint sb;
        longint sr;
        ua  = longint'(ma);
        ub  = longint'(mb);
        sa  = (ua >= 32768) ? ua - 65536 : ua;
        sb  = (ub >= 32768) ? ub - 65536 : ub;
        sr  = ms ? (sa - sb) : (sa + sb);
        res = ms ? (ma - mb) : (ma + mb);
        co  = ms ? (ua >= ub) : ((ua + ub) > 65535);
        ov  = OVF_EN && ((sr > 32767) || (sr < -32768));
    endtask

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic ts,
                            input logic [W-1:0] er, input logic ec, input logic eo,
                            input string nm, input bit noise);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk({nm, " ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        a = ta; b = tb_b; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; sub = ~ts;
        chk({nm, " busy_in_ready"}, {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            if (noise) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b0;
        chk({nm, " latency"}, n, NSLICE);
        chk({nm, " result"}, {16'd0, result}, {16'd0, er});
        chk({nm, " cout"}, {31'd0, cout}, {31'd0, ec});
        chk({nm, " ovf"}, {31'd0, ovf}, {31'd0, eo});
    endtask

    task automatic finish_op(input string nm, input int hold, input logic [W-1:0] er);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({nm, " hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({nm, " hold_result"}, {16'd0, result}, {16'd0, er});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, " post_valid"}, {31'd0, out_valid}, 32'd0);
        chk({nm, " post_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        logic [W-1:0] er;
        logic         ec;
        logic         eo;

        checks = 0; failures = 0;
        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[3] = '{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 16'h0000; b = 16'h0000; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd0);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset result", {16'd0, result}, 32'd0);
        chk("reset cout", {31'd0, cout}, 32'd0);
        chk("reset ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("idle in_ready", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].res, vecs[i].co,
                     vecs[i].ov & OVF_EN, $sformatf("vec%0d", i), 1'b0);
            finish_op($sformatf("vec%0d", i), 0, vecs[i].res);
        end

        // Backpressure: held DONE ignores a new in_valid pulse
        start_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, "bp", 1'b0);
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 1);
            a = 16'hAAAA; b = 16'h5555; sub = 1'b0;
            @(posedge clk); #1;
            chk("bp valid", {31'd0, out_valid}, 32'd1);
            chk("bp result", {16'd0, result}, 32'h2233);
            chk("bp cout", {31'd0, cout}, 32'd0);
            chk("bp in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        finish_op("bp", 0, 16'h2233);
        chk("bp idle_hold_result", {16'd0, result}, 32'h2233);
        @(posedge clk); #1;
        chk("bp not_queued", {31'd0, out_valid | ~in_ready}, 32'd0);

        // Reset during the second COMPUTE cycle
        a = 16'hFFFF; b = 16'h0001; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst result", {16'd0, result}, 32'd0);
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst cout", {31'd0, cout}, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst held out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst held in_ready", {31'd0, in_ready}, 32'd0);
        end
        rst_n = 1'b1;
        #1;
        start_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, "post_rst", 1'b0);
        finish_op("post_rst", 0, 16'h0002);

        // Randomized operations with random backpressure and out_ready noise
        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: ra = 16'h7FFF;
                1: rb = 16'h8000;
                2: ra = 16'hFFFF;
                3: rb = ra;
                default: ra = ra;
            endcase
            model(ra, rb, rs, er, ec, eo);
            start_op(ra, rb, rs, er, ec, eo, $sformatf("rnd%0d", i), 1'b1);
            finish_op($sformatf("rnd%0d", i), $urandom_range(0, 2), er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
